// File: rtl/snake_input_queue_if.sv
`default_nettype none
// snake_input_queue_if: per-channel buttons, game tick and head direction in; committed direction and queue status out.
interface snake_input_queue_if #(
  parameter int PLAYERS = 2
);
  logic [4*PLAYERS-1:0] i_btn;
  logic                 i_tick;
  logic [2*PLAYERS-1:0] i_head_dir;
  logic [2*PLAYERS-1:0] o_dir;
  logic [PLAYERS-1:0]   o_start;
  logic [PLAYERS-1:0]   o_new_user_input;
  logic [PLAYERS-1:0]   o_overflow;

  modport master (
    output i_btn, i_tick, i_head_dir,
    input  o_dir, o_start, o_new_user_input, o_overflow
  );

  modport slave (
    input  i_btn, i_tick, i_head_dir,
    output o_dir, o_start, o_new_user_input, o_overflow
  );
endinterface
`default_nettype wire

// File: rtl/snake_input_queue.sv
`default_nettype none
// snake_input_queue: per-player turn validation and DEPTH-entry turn queue released one entry per game tick.
// Define SNAKE_INPUT_EDGE_EN to request on button rising edges instead of button levels.
module snake_input_queue #(
  parameter int PLAYERS = 2,
  parameter int DEPTH   = 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  snake_input_queue_if.slave bus
);
  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  genvar p;
  generate
    for (p = 0; p < PLAYERS; p++) begin : g_ch
      logic [3:0]    btn;
      logic [3:0]    req;
      logic [1:0]    queue [DEPTH];
      logic [PW-1:0] rd_ptr;
      logic [PW-1:0] wr_ptr;
      logic [PW-1:0] newest_ptr;
      logic [CW-1:0] count;
      logic [1:0]    dir;
      logic [1:0]    cand;
      logic [1:0]    ref_dir;
      logic          start;
      logic          overflow;
      logic          cand_valid;
      logic          accept;
      logic          empty;
      logic          full;

      assign btn = bus.i_btn[4*p +: 4];

`ifdef SNAKE_INPUT_EDGE_EN
      logic [3:0] btn_prev;
      always_ff @(posedge clk) begin
        if (!rst_n) btn_prev <= '0;
        else        btn_prev <= btn;
      end
      assign req = btn & ~btn_prev;
`else
      assign req = btn;
`endif

      assign empty      = (count == '0);
      assign full       = (count == FULL_CNT);
      assign newest_ptr = (wr_ptr == '0) ? LAST_PTR : wr_ptr - PW'(1);

      // Button bits are {right, left, down, up}; lowest set bit wins.
      always_comb begin
        cand_valid = |req;
        cand       = 2'b00;
        if (req[0])      cand = 2'b00;
        else if (req[1]) cand = 2'b01;
        else if (req[2]) cand = 2'b10;
        else if (req[3]) cand = 2'b11;
      end

      // Before the first command the snake is treated as heading down, but only down itself is refused.
      always_comb begin
        ref_dir = empty ? bus.i_head_dir[2*p +: 2] : queue[newest_ptr];
        if (empty && !start)
          accept = cand_valid && (cand != 2'b01);
        else
          accept = cand_valid && (cand != ref_dir) && (cand != {ref_dir[1], ~ref_dir[0]});
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_ptr   <= '0;
          wr_ptr   <= '0;
          count    <= '0;
          dir      <= 2'b01;
          start    <= 1'b0;
          overflow <= 1'b0;
          for (int i = 0; i < DEPTH; i++) queue[i] <= 2'b00;
        end else begin
          overflow <= 1'b0;
          if (accept) start <= 1'b1;
          if (bus.i_tick && empty) begin
            if (accept) dir <= cand;
          end else if (bus.i_tick) begin
            // A push into a full queue reuses the slot freed by this pop.
            dir    <= queue[rd_ptr];
            rd_ptr <= ptr_inc(rd_ptr);
            if (accept) begin
              queue[wr_ptr] <= cand;
              wr_ptr        <= ptr_inc(wr_ptr);
            end else begin
              count <= count - CW'(1);
            end
          end else if (accept) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              queue[wr_ptr] <= cand;
              wr_ptr        <= ptr_inc(wr_ptr);
              count         <= count + CW'(1);
            end
          end
        end
      end

      assign bus.o_dir[2*p +: 2]       = dir;
      assign bus.o_start[p]            = start;
      assign bus.o_new_user_input[p]   = !empty;
      assign bus.o_overflow[p]         = overflow;
    end
  endgenerate
endmodule
`default_nettype wire
